stepper_position_tracker: RTL and testbench

- Tracks the live position of one stepper axis (extruder e0 and siblings) by counting step/dir pulses from the motion generator.
- Output position_out is 31 bits and feeds the in_port of the downstream Avalon PIO read port, so software can read the position.
- Includes an endstop-driven homing sequencer that zeroes the count on the endstop edge, plus a software clear/load path.

---
 rtl/stepper_position_tracker_pkg.sv | 16 +
 rtl/stepper_position_tracker_in_sync_edge.sv | 29 ++
 rtl/stepper_position_tracker.sv | 175 +++++++++++++++++
 tb/tb_stepper_position_tracker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_position_tracker_pkg.sv
// Shared types and constants for the stepper position tracker.
package stepper_position_tracker_pkg;

    localparam int POS_W_DEFAULT = 31;

    typedef enum logic [1:0] {
        HOME_IDLE = 2'd0,
        HOME_SEEK = 2'd1,
        HOME_DONE = 2'd2
    } home_state_t;

    // Signed limits of the default-width count; wrap is flagged when stepping past them.
    localparam logic [POS_W_DEFAULT-1:0] POS_MAX = {1'b0, {(POS_W_DEFAULT-1){1'b1}}};
    localparam logic [POS_W_DEFAULT-1:0] POS_MIN = {1'b1, {(POS_W_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/stepper_position_tracker_in_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with a rising-edge strobe
// derived from the last stage and a one-cycle delayed copy of it.
module stepper_position_tracker_in_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/stepper_position_tracker.sv
// Step/dir position counter with endstop homing and software clear/load.
// Build option: define STEP_GLITCH_FILTER_EN to require FILT_CYC synced-high cycles per step.
module stepper_position_tracker
    import stepper_position_tracker_pkg::*;
#(
    parameter int POS_W       = POS_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int DIR_INVERT  = 0,
    parameter int FILT_CYC    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             endstop_in,
    input  logic             clear,
    input  logic             load,
    input  logic [POS_W-1:0] load_val,
    input  logic             home_start,
    input  logic             home_abort,
    output logic [POS_W-1:0] position_out,
    output logic             wrap_flag,
    output logic             homed,
    output logic             homing_busy,
    output logic             home_done,
    output logic [1:0]       home_state_dbg
);

    localparam logic [POS_W-1:0] LIM_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] LIM_MIN = {1'b1, {(POS_W-1){1'b0}}};

    logic step_level;
    logic step_rise;
    logic dir_level;
    logic dir_edge_unused;
    logic endstop_level_unused;
    logic endstop_rise;
    logic step_fire;
    logic dir_eff;

    stepper_position_tracker_in_sync_edge #(.STAGES(SYNC_STAGES)) u_step_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (step_in),
        .level    (step_level),
        .rise     (step_rise)
    );

    stepper_position_tracker_in_sync_edge #(.STAGES(SYNC_STAGES)) u_dir_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (dir_in),
        .level    (dir_level),
        .rise     (dir_edge_unused)
    );

    stepper_position_tracker_in_sync_edge #(.STAGES(SYNC_STAGES)) u_endstop_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (endstop_in),
        .level    (endstop_level_unused),
        .rise     (endstop_rise)
    );

`ifdef STEP_GLITCH_FILTER_EN
    localparam int RUN_W = $clog2(FILT_CYC + 1);

    logic [RUN_W-1:0] run_q;
    logic             step_rise_unused;

    // Run length saturates at FILT_CYC so a long pulse fires exactly once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= '0;
        end else if (!step_level) begin
            run_q <= '0;
        end else if (run_q != RUN_W'(FILT_CYC)) begin
            run_q <= run_q + RUN_W'(1);
        end
    end

    assign step_fire        = step_level && (run_q == RUN_W'(FILT_CYC - 1));
    assign step_rise_unused = step_rise;
`else
    localparam int FILT_CYC_UNUSED = FILT_CYC;

    assign step_fire = step_rise;
`endif

    assign dir_eff = dir_level ^ (DIR_INVERT != 0);

    home_state_t state_q;
    home_state_t state_d;
    logic        home_zero;
    logic        home_start_taken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HOME_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort outranks a coincident endstop edge, so zeroing happens only without abort.
    always_comb begin
        state_d          = state_q;
        home_zero        = 1'b0;
        home_start_taken = 1'b0;
        case (state_q)
            HOME_IDLE: begin
                if (home_start) begin
                    state_d          = HOME_SEEK;
                    home_start_taken = 1'b1;
                end
            end
            HOME_SEEK: begin
                if (home_abort) begin
                    state_d = HOME_IDLE;
                end else if (endstop_rise) begin
                    state_d   = HOME_DONE;
                    home_zero = 1'b1;
                end
            end
            HOME_DONE: begin
                state_d = HOME_IDLE;
            end
            default: begin
                state_d = HOME_IDLE;
            end
        endcase
    end

    assign homing_busy    = (state_q == HOME_SEEK);
    assign home_done      = (state_q == HOME_DONE);
    assign home_state_dbg = state_q;

    // A step that coincides with clear, load or the homing zero is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            position_out <= '0;
            wrap_flag    <= 1'b0;
        end else if (clear) begin
            position_out <= '0;
            wrap_flag    <= 1'b0;
        end else if (load) begin
            position_out <= load_val;
        end else if (home_zero) begin
            position_out <= '0;
        end else if (step_fire) begin
            if (dir_eff) begin
                position_out <= position_out + POS_W'(1);
                if (position_out == LIM_MAX) begin
                    wrap_flag <= 1'b1;
                end
            end else begin
                position_out <= position_out - POS_W'(1);
                if (position_out == LIM_MIN) begin
                    wrap_flag <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            homed <= 1'b0;
        end else if (clear || load || home_start_taken) begin
            homed <= 1'b0;
        end else if (home_zero) begin
            homed <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stepper_position_tracker.sv
// Directed bench for stepper_position_tracker; follows STEP_GLITCH_FILTER_EN if defined.
module tb_stepper_position_tracker;
    import stepper_position_tracker_pkg::*;

    localparam int POS_W = 31;
`ifdef STEP_GLITCH_FILTER_EN
    localparam int LAT      = 6;
    localparam int PULSE_HI = 6;
`else
    localparam int LAT      = 3;
    localparam int PULSE_HI = 2;
`endif

    logic             clk        = 1'b0;
    logic             reset_n    = 1'b0;
    logic             step_in    = 1'b0;
    logic             dir_in     = 1'b0;
    logic             endstop_in = 1'b0;
    logic             clear      = 1'b0;
    logic             load       = 1'b0;
    logic [POS_W-1:0] load_val   = '0;
    logic             home_start = 1'b0;
    logic             home_abort = 1'b0;
    logic [POS_W-1:0] position_out;
    logic             wrap_flag;
    logic             homed;
    logic             homing_busy;
    logic             home_done;
    logic [1:0]       home_state_dbg;

    int errors = 0;
    int checks = 0;

    stepper_position_tracker dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .step_in        (step_in),
        .dir_in         (dir_in),
        .endstop_in     (endstop_in),
        .clear          (clear),
        .load           (load),
        .load_val       (load_val),
        .home_start     (home_start),
        .home_abort     (home_abort),
        .position_out   (position_out),
        .wrap_flag      (wrap_flag),
        .homed          (homed),
        .homing_busy    (homing_busy),
        .home_done      (home_done),
        .home_state_dbg (home_state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_step();
        step_in = 1'b1;
        cyc(PULSE_HI);
        step_in = 1'b0;
        cyc(2);
    endtask

    task automatic do_load(input logic [POS_W-1:0] v);
        load_val = v;
        load     = 1'b1;
        cyc(1);
        load     = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    task automatic do_home_start();
        home_start = 1'b1;
        cyc(1);
        home_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc(2);
        check("rst_pos", 32'(position_out), 32'd0);
        check("rst_wrap", 32'(wrap_flag), 32'd0);
        check("rst_homed", 32'(homed), 32'd0);
        check("rst_busy", 32'(homing_busy), 32'd0);
        check("rst_done", 32'(home_done), 32'd0);
        check("rst_state", 32'(home_state_dbg), 32'(HOME_IDLE));
        reset_n = 1'b1;

        // First step latency, then 5 up and 2 down.
        dir_in = 1'b1;
        cyc(3);
        step_in = 1'b1;
        cyc(LAT - 1);
        check("lat_before", 32'(position_out), 32'd0);
        cyc(1);
        check("lat_first", 32'(position_out), 32'd1);
        cyc(1);
        step_in = 1'b0;
        cyc(2);
        for (int i = 0; i < 4; i++) pulse_step();
        check("up5", 32'(position_out), 32'd5);
        dir_in = 1'b0;
        cyc(3);
        pulse_step();
        pulse_step();
        cyc(1);
        check("net3", 32'(position_out), 32'd3);

        dir_in = 1'b1;
        cyc(3);
`ifdef STEP_GLITCH_FILTER_EN
        step_in = 1'b1;
        cyc(2);
        step_in = 1'b0;
        cyc(8);
        check("glitch_short", 32'(position_out), 32'd3);
        step_in = 1'b1;
        cyc(5);
        check("glitch_long_pre", 32'(position_out), 32'd3);
        cyc(1);
        check("glitch_long_hit", 32'(position_out), 32'd4);
        step_in = 1'b0;
        cyc(4);
        check("glitch_long_once", 32'(position_out), 32'd4);
`else
        step_in = 1'b1;
        cyc(1);
        step_in = 1'b0;
        cyc(4);
        check("one_cycle_step", 32'(position_out), 32'd4);
`endif

        // Positive wrap, clear, negative wrap, load keeps wrap.
        do_load(31'h3FFF_FFFF);
        check("load_max", 32'(position_out), 32'h3FFF_FFFF);
        check("load_max_wrap", 32'(wrap_flag), 32'd0);
        pulse_step();
        cyc(1);
        check("wrap_pos_val", 32'(position_out), 32'h4000_0000);
        check("wrap_pos_flag", 32'(wrap_flag), 32'd1);
        do_clear();
        check("clear_pos", 32'(position_out), 32'd0);
        check("clear_wrap", 32'(wrap_flag), 32'd0);
        do_load(31'h4000_0000);
        dir_in = 1'b0;
        cyc(3);
        pulse_step();
        cyc(1);
        check("wrap_neg_val", 32'(position_out), 32'h3FFF_FFFF);
        check("wrap_neg_flag", 32'(wrap_flag), 32'd1);
        do_load(31'd5);
        check("load_keeps_wrap", 32'(wrap_flag), 32'd1);
        check("load_5", 32'(position_out), 32'd5);
        do_clear();
        check("clear2_wrap", 32'(wrap_flag), 32'd0);

        // Normal homing run.
        do_load(31'd100);
        do_home_start();
        check("seek_busy", 32'(homing_busy), 32'd1);
        check("seek_state", 32'(home_state_dbg), 32'(HOME_SEEK));
        for (int i = 0; i < 7; i++) pulse_step();
        cyc(1);
        check("seek_count", 32'(position_out), 32'd93);
        endstop_in = 1'b1;
        cyc(2);
        check("es_pre_done", 32'(home_done), 32'd0);
        check("es_pre_pos", 32'(position_out), 32'd93);
        cyc(1);
        check("home_done_hi", 32'(home_done), 32'd1);
        check("home_zero", 32'(position_out), 32'd0);
        check("homed_set", 32'(homed), 32'd1);
        check("home_busy_off", 32'(homing_busy), 32'd0);
        cyc(1);
        check("home_done_lo", 32'(home_done), 32'd0);
        check("home_back_idle", 32'(home_state_dbg), 32'(HOME_IDLE));
        check("homed_sticky", 32'(homed), 32'd1);
        endstop_in = 1'b0;
        cyc(3);

        // Endstop outside SEEK, and endstop already high on entry.
        do_load(31'd20);
        check("load_clr_homed", 32'(homed), 32'd0);
        endstop_in = 1'b1;
        cyc(4);
        check("es_idle_noeff", 32'(position_out), 32'd20);
        do_home_start();
        cyc(4);
        check("es_high_busy", 32'(homing_busy), 32'd1);
        check("es_high_pos", 32'(position_out), 32'd20);
        endstop_in = 1'b0;
        cyc(3);
        endstop_in = 1'b1;
        cyc(3);
        check("es_relow_done", 32'(home_done), 32'd1);
        check("es_relow_pos", 32'(position_out), 32'd0);
        endstop_in = 1'b0;
        cyc(3);

        // Abort in SEEK.
        do_load(31'd40);
        do_home_start();
        cyc(2);
        home_abort = 1'b1;
        cyc(1);
        home_abort = 1'b0;
        check("abort_busy", 32'(homing_busy), 32'd0);
        check("abort_homed", 32'(homed), 32'd0);
        check("abort_pos", 32'(position_out), 32'd40);
        endstop_in = 1'b1;
        cyc(4);
        check("abort_es_noeff", 32'(position_out), 32'd40);
        endstop_in = 1'b0;
        cyc(3);

        // Abort coincident with the endstop edge.
        do_home_start();
        check("abort2_busy", 32'(homing_busy), 32'd1);
        endstop_in = 1'b1;
        cyc(2);
        home_abort = 1'b1;
        cyc(1);
        home_abort = 1'b0;
        check("abort_edge_pos", 32'(position_out), 32'd40);
        check("abort_edge_state", 32'(home_state_dbg), 32'(HOME_IDLE));
        check("abort_edge_done", 32'(home_done), 32'd0);
        check("abort_edge_homed", 32'(homed), 32'd0);
        endstop_in = 1'b0;
        cyc(3);

        // Step coincident with clear, then with load.
        step_in = 1'b1;
        cyc(LAT - 1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        cyc(1);
        step_in = 1'b0;
        cyc(LAT + 1);
        check("step_vs_clear", 32'(position_out), 32'd0);
        step_in = 1'b1;
        cyc(LAT - 1);
        load_val = 31'd55;
        load = 1'b1;
        cyc(1);
        load = 1'b0;
        cyc(1);
        step_in = 1'b0;
        cyc(LAT + 1);
        check("step_vs_load", 32'(position_out), 32'd55);

        // Reset in the middle of homing.
        do_home_start();
        cyc(2);
        check("pre_rst_busy", 32'(homing_busy), 32'd1);
        reset_n = 1'b0;
        #2;
        check("midrst_pos", 32'(position_out), 32'd0);
        check("midrst_busy", 32'(homing_busy), 32'd0);
        check("midrst_state", 32'(home_state_dbg), 32'(HOME_IDLE));
        check("midrst_homed", 32'(homed), 32'd0);
        reset_n = 1'b1;
        cyc(2);
        check("post_rst_done", 32'(home_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
